// File: rtl/mcu_rst_pkg.sv
// Shared types and constants for the MCU reset sequencer.
package mcu_rst_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } rst_state_e;

  // rst_cause value reported for a power-on / board reset sequence
  localparam int unsigned CAUSE_POR = 0;

  // Ceiling log2 usable in constant expressions
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mcu_rst_sync.sv
// Multi-flop synchroniser with asynchronous reset to a selectable value.
module mcu_rst_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous input through the chain; reset forces RST_VAL
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/mcu_rst_seq.sv
// Parametrised reset sequencer: synchronises board and soft resets, holds the
// affected domains, then releases them outer-to-inner with a fixed stagger.
module mcu_rst_seq
  import mcu_rst_pkg::*;
#(
  parameter  int unsigned NUM_DOM     = 3,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned HOLD_CYCLES = 16,
  parameter  int unsigned STAGGER     = 4,
  localparam int unsigned CAUSE_W     = clog2(NUM_DOM + 1)
) (
  input  logic               sys_clk,
  input  logic               mcu_rst,
  input  logic [NUM_DOM-1:0] soft_rst_req,
  output logic [NUM_DOM-1:0] dom_rst_b,
  output logic               rst_busy,
  output logic [CAUSE_W-1:0] rst_cause
);

  localparam int unsigned IDX_W   = (NUM_DOM > 1) ? clog2(NUM_DOM) : 1;
  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   HOLD_TERM = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STAG_TERM = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CAUSE_W-1:0] CAUSE_P   = CAUSE_W'(CAUSE_POR);

  logic                 por_pending;
  logic [NUM_DOM-1:0]   soft_sync;
  logic [NUM_DOM-1:0]   soft_prev;
  logic [NUM_DOM-1:0]   req_edge;
  logic                 req_any;
  logic [IDX_W-1:0]     req_idx;
  logic [IDX_W-1:0]     acc_scope;
  logic                 req_accept;
  logic [IDX_W-1:0]     next_idx;

  rst_state_e           state;
  logic [IDX_W-1:0]     scope;
  logic [IDX_W-1:0]     rel_idx;
  logic [CNT_W-1:0]     cnt;

  // Board reset release: held at 1 while mcu_rst is high, then shifts in 0
  mcu_rst_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_por_sync (
    .clk      (sys_clk),
    .rst      (mcu_rst),
    .async_in (1'b0),
    .sync_out (por_pending)
  );

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_soft_sync
    mcu_rst_sync #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0)
    ) u_soft_sync (
      .clk      (sys_clk),
      .rst      (mcu_rst),
      .async_in (soft_rst_req[g]),
      .sync_out (soft_sync[g])
    );
  end

  // Previous synchronised request level for rising-edge detection
  always_ff @(posedge sys_clk or posedge mcu_rst) begin
    if (mcu_rst) begin
      soft_prev <= '0;
    end else begin
      soft_prev <= soft_sync;
    end
  end

  // Edge detect, highest-domain priority encode and acceptance decision
  always_comb begin
    req_edge = soft_sync & ~soft_prev;
    req_any  = 1'b0;
    req_idx  = '0;
    for (int unsigned i = 0; i < NUM_DOM; i++) begin
      if (req_edge[i]) begin
        req_any = 1'b1;
        req_idx = IDX_W'(i);
      end
    end
    // A request arriving mid soft sequence can only widen the scope
    acc_scope  = (state != ST_RUN && scope > req_idx) ? scope : req_idx;
    // Requests are ignored while a POR sequence is still running
    req_accept = req_any && (state == ST_RUN || rst_cause != CAUSE_P);
    next_idx   = rel_idx - IDX_W'(1);
  end

  // Sequencer FSM with shared hold/stagger counter and registered outputs
  always_ff @(posedge sys_clk or posedge mcu_rst) begin
    if (mcu_rst) begin
      state     <= ST_HOLD;
      scope     <= IDX_W'(NUM_DOM - 1);
      rel_idx   <= IDX_W'(NUM_DOM - 1);
      cnt       <= '0;
      dom_rst_b <= '0;
      rst_busy  <= 1'b1;
      rst_cause <= CAUSE_P;
    end else if (req_accept) begin
      state     <= ST_HOLD;
      scope     <= acc_scope;
      rel_idx   <= acc_scope;
      cnt       <= '0;
      rst_busy  <= 1'b1;
      rst_cause <= CAUSE_W'(acc_scope) + CAUSE_W'(1);
      for (int unsigned i = 0; i < NUM_DOM; i++) begin
        if (i <= int'(acc_scope)) begin
          dom_rst_b[i] <= 1'b0;
        end
      end
    end else begin
      case (state)
        ST_HOLD: begin
          if (!por_pending) begin
            // The first release coincides with the hold terminal edge
            if (cnt == HOLD_TERM) begin
              dom_rst_b[scope] <= 1'b1;
              rel_idx          <= scope;
              cnt              <= '0;
              if (scope == '0) begin
                state    <= ST_RUN;
                rst_busy <= 1'b0;
              end else begin
                state <= ST_RELEASE;
              end
            end else if (cnt != CNT_SAT) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (cnt == STAG_TERM) begin
            dom_rst_b[next_idx] <= 1'b1;
            rel_idx             <= next_idx;
            cnt                 <= '0;
            if (next_idx == '0) begin
              state    <= ST_RUN;
              rst_busy <= 1'b0;
            end
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          dom_rst_b <= '1;
          rst_busy  <= 1'b0;
        end
        default: begin
          state <= ST_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_rst_seq.sv
// Directed self-checking bench for mcu_rst_seq with default parameters.
module tb_mcu_rst_seq;

  logic       sys_clk = 1'b0;
  logic       mcu_rst;
  logic [2:0] soft_rst_req;
  logic [2:0] dom_rst_b;
  logic       rst_busy;
  logic [1:0] rst_cause;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 sys_clk = ~sys_clk;

  mcu_rst_seq #(
    .NUM_DOM     (3),
    .SYNC_STAGES (2),
    .HOLD_CYCLES (16),
    .STAGGER     (4)
  ) dut (
    .sys_clk      (sys_clk),
    .mcu_rst      (mcu_rst),
    .soft_rst_req (soft_rst_req),
    .dom_rst_b    (dom_rst_b),
    .rst_busy     (rst_busy),
    .rst_cause    (rst_cause)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic edges(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Full POR release timing, called right after mcu_rst has been dropped
  task automatic por_seq(input string tag);
    edges(17);
    check_val({tag, " e17 dom"}, dom_rst_b, 3'b000);
    check_val({tag, " e17 busy"}, rst_busy, 1'b1);
    edges(1);
    check_val({tag, " e18 dom"}, dom_rst_b, 3'b100);
    edges(3);
    check_val({tag, " e21 dom"}, dom_rst_b, 3'b100);
    edges(1);
    check_val({tag, " e22 dom"}, dom_rst_b, 3'b110);
    edges(3);
    check_val({tag, " e25 dom"}, dom_rst_b, 3'b110);
    check_val({tag, " e25 busy"}, rst_busy, 1'b1);
    edges(1);
    check_val({tag, " e26 dom"}, dom_rst_b, 3'b111);
    check_val({tag, " e26 busy"}, rst_busy, 1'b0);
    check_val({tag, " e26 cause"}, rst_cause, 2'd0);
  endtask

  initial begin
    mcu_rst      = 1'b1;
    soft_rst_req = 3'b000;

    // 1: POR pulse of 5 cycles
    edges(5);
    check_val("t1 rst dom", dom_rst_b, 3'b000);
    check_val("t1 rst busy", rst_busy, 1'b1);
    check_val("t1 rst cause", rst_cause, 2'd0);
    mcu_rst = 1'b0;
    por_seq("t1");

    // 2: soft request on domain 0 only
    soft_rst_req = 3'b001;
    edges(2);
    check_val("t2 e2 dom", dom_rst_b, 3'b111);
    edges(1);
    check_val("t2 e3 dom", dom_rst_b, 3'b110);
    check_val("t2 e3 cause", rst_cause, 2'd1);
    check_val("t2 e3 busy", rst_busy, 1'b1);
    edges(15);
    check_val("t2 e18 dom", dom_rst_b, 3'b110);
    edges(1);
    check_val("t2 e19 dom", dom_rst_b, 3'b111);
    check_val("t2 e19 busy", rst_busy, 1'b0);
    check_val("t2 e19 cause", rst_cause, 2'd1);
    soft_rst_req = 3'b000;
    edges(4);

    // 3: simultaneous requests on domains 1 and 2, highest wins
    soft_rst_req = 3'b110;
    edges(3);
    check_val("t3 e3 dom", dom_rst_b, 3'b000);
    check_val("t3 e3 cause", rst_cause, 2'd3);
    edges(15);
    check_val("t3 e18 dom", dom_rst_b, 3'b000);
    edges(1);
    check_val("t3 e19 dom", dom_rst_b, 3'b100);
    edges(4);
    check_val("t3 e23 dom", dom_rst_b, 3'b110);
    edges(3);
    check_val("t3 e26 busy", rst_busy, 1'b1);
    edges(1);
    check_val("t3 e27 dom", dom_rst_b, 3'b111);
    check_val("t3 e27 busy", rst_busy, 1'b0);
    soft_rst_req = 3'b000;
    edges(4);

    // 4: domain 0 request, then domain 2 request 5 cycles later upgrades scope
    soft_rst_req = 3'b001;
    edges(3);
    check_val("t4 e3 dom", dom_rst_b, 3'b110);
    edges(2);
    soft_rst_req = 3'b101;
    edges(2);
    check_val("t4 e7 dom", dom_rst_b, 3'b110);
    check_val("t4 e7 cause", rst_cause, 2'd1);
    edges(1);
    check_val("t4 e8 dom", dom_rst_b, 3'b000);
    check_val("t4 e8 cause", rst_cause, 2'd3);
    edges(15);
    check_val("t4 e23 dom", dom_rst_b, 3'b000);
    edges(1);
    check_val("t4 e24 dom", dom_rst_b, 3'b100);
    edges(4);
    check_val("t4 e28 dom", dom_rst_b, 3'b110);
    edges(4);
    check_val("t4 e32 dom", dom_rst_b, 3'b111);
    check_val("t4 e32 busy", rst_busy, 1'b0);
    soft_rst_req = 3'b000;
    edges(4);

    // 5: board reset during release of a soft sequence; held request is discarded in POR
    soft_rst_req = 3'b100;
    edges(19);
    check_val("t5 e19 dom", dom_rst_b, 3'b100);
    edges(1);
    mcu_rst = 1'b1;
    #1;
    check_val("t5 async dom", dom_rst_b, 3'b000);
    check_val("t5 async cause", rst_cause, 2'd0);
    check_val("t5 async busy", rst_busy, 1'b1);
    edges(3);
    mcu_rst = 1'b0;
    por_seq("t5");
    soft_rst_req = 3'b000;
    edges(4);
    check_val("t5 idle dom", dom_rst_b, 3'b111);

    // 6: level held high yields exactly one sequence until it drops and rises
    soft_rst_req = 3'b010;
    edges(3);
    check_val("t6 e3 dom", dom_rst_b, 3'b100);
    check_val("t6 e3 cause", rst_cause, 2'd2);
    edges(16);
    check_val("t6 e19 dom", dom_rst_b, 3'b110);
    edges(4);
    check_val("t6 e23 dom", dom_rst_b, 3'b111);
    check_val("t6 e23 busy", rst_busy, 1'b0);
    edges(30);
    check_val("t6 held dom", dom_rst_b, 3'b111);
    check_val("t6 held busy", rst_busy, 1'b0);
    soft_rst_req = 3'b000;
    edges(4);
    soft_rst_req = 3'b010;
    edges(3);
    check_val("t6 rearm dom", dom_rst_b, 3'b100);
    check_val("t6 rearm busy", rst_busy, 1'b1);
    soft_rst_req = 3'b000;
    edges(25);
    check_val("t6 end dom", dom_rst_b, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
